// File: rtl/alu_share_arb.sv
// alu_share_arb: two-requester round-robin front end that
// time-shares one external combinational 32-bit ALU.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   req0_* / req1_*         valid/ready request channels
//                           (op code, operands a/b)
//   rsp0_* / rsp1_*         valid/ready response handshakes
//   rsp_result, rsp_z/n/v   shared registered response
//   alu_gin, alu_a, alu_b   registered drive to the ALU
//   alu_sum, alu_zout,      ALU result and flags
//   alu_v                   (the ALU's N flag is not used)
//   ops_done                wrapping completion counter
//   rsp_err                 illegal-op flag, only present
//                           when ALU_SHARE_ARB_ILLEGAL_OP_EN
//                           is defined
//
// Build option ALU_SHARE_ARB_ILLEGAL_OP_EN: unknown op codes
// bypass the ALU and return a zero result with rsp_err=1.

module alu_share_arb #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_z,
  output logic             rsp_n,
  output logic             rsp_v,

  output logic [2:0]       alu_gin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_zout,
  input  logic             alu_v,

  output logic [CNT_W-1:0] ops_done
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
  ,
  output logic             rsp_err
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // state and arbitration
  logic [1:0]       r_state;
  logic             r_last_grant;
  logic             r_grant;

  // latched request, drives the ALU directly
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // registered response
  logic [WIDTH-1:0] r_result;
  logic             r_z;
  logic             r_n;
  logic             r_v;
  logic [CNT_W-1:0] r_cnt;

  logic             w_idle;
  logic             w_exec;
  logic             w_resp;
  logic             w_pick1;
  logic             w_accept;
  logic             w_done;
  logic             w_legal;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_n;
  logic             w_v;

  assign w_idle = (r_state == S_IDLE);
  assign w_exec = (r_state == S_EXEC);
  assign w_resp = (r_state == S_RESP);

  // Requester 1 wins when alone, or on a tie when
  // requester 0 was the one served last.
  assign w_pick1 = req1_valid &
                   (~req0_valid | ~r_last_grant);

  assign w_accept = w_idle & (req0_valid | req1_valid);

  assign req0_ready = w_idle & req0_valid & ~w_pick1;
  assign req1_ready = w_idle & w_pick1;

  assign w_op = w_pick1 ? req1_op : req0_op;
  assign w_a  = w_pick1 ? req1_a  : req0_a;
  assign w_b  = w_pick1 ? req1_b  : req0_b;

  assign w_done = w_resp &
                  (r_grant ? rsp1_ready : rsp0_ready);

`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
  always_comb begin
    w_legal = 1'b0;
    unique case (w_op)
      OP_AND,
      OP_OR,
      OP_ADD,
      OP_SUB,
      OP_SLT:  w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end
`else
  assign w_legal = 1'b1;
`endif

  // Flag normalisation: SLT reports the compare bit as
  // "negative"; overflow only means something for ADD/SUB.
  always_comb begin
    w_n = alu_sum[WIDTH-1];
    w_v = 1'b0;
    unique case (r_op)
      OP_SLT: w_n = alu_sum[0];
      OP_ADD,
      OP_SUB: w_v = alu_v;
      default: begin
        w_n = alu_sum[WIDTH-1];
        w_v = 1'b0;
      end
    endcase
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept)
            r_state <= w_legal ? S_EXEC : S_RESP;
        end
        S_EXEC: r_state <= S_RESP;
        S_RESP: begin
          if (w_done)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request latch. Illegal codes never reach the ALU, so
  // the operand registers keep their previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= 1'b0;
      r_op    <= 3'b000;
      r_a     <= '0;
      r_b     <= '0;
    end else if (w_accept) begin
      r_grant <= w_pick1;
      if (w_legal) begin
        r_op <= w_op;
        r_a  <= w_a;
        r_b  <= w_b;
      end
    end
  end

  // Response capture; held untouched through RESP stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
    end else if (w_exec) begin
      r_result <= alu_sum;
      r_z      <= alu_zout;
      r_n      <= w_n;
      r_v      <= w_v;
    end else if (w_accept && !w_legal) begin
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
    end
  end

`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (w_accept)
      r_err <= ~w_legal;
  end

  assign rsp_err = r_err;
`endif

  // Completion bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
    end else if (w_done) begin
      r_last_grant <= r_grant;
      r_cnt        <= r_cnt + 1'b1;
    end
  end

  assign rsp0_valid = w_resp & ~r_grant;
  assign rsp1_valid = w_resp &  r_grant;
  assign rsp_result = r_result;
  assign rsp_z      = r_z;
  assign rsp_n      = r_n;
  assign rsp_v      = r_v;

  assign alu_gin  = r_op;
  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign ops_done = r_cnt;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed bench for alu_share_arb.
// Models the external 32-bit ALU and checks each step.

module tb_alu_share_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_z, rsp_n, rsp_v;
  logic [2:0]  alu_gin;
  logic [31:0] alu_a, alu_b, alu_sum;
  logic        alu_zout, alu_v;
  logic [15:0] ops_done;
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
  logic        rsp_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  alu_share_arb #(.WIDTH(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result),
    .rsp_z      (rsp_z),
    .rsp_n      (rsp_n),
    .rsp_v      (rsp_v),
    .alu_gin    (alu_gin),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sum    (alu_sum),
    .alu_zout   (alu_zout),
    .alu_v      (alu_v),
    .ops_done   (ops_done)
`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
    ,
    .rsp_err    (rsp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference combinational ALU
  always_comb begin
    alu_sum = 32'h0;
    alu_v   = 1'b0;
    case (alu_gin)
      3'b000: alu_sum = alu_a & alu_b;
      3'b001: alu_sum = alu_a | alu_b;
      3'b010: begin
        alu_sum = alu_a + alu_b;
        alu_v = (alu_a[31] == alu_b[31]) &&
                (alu_sum[31] != alu_a[31]);
      end
      3'b110: begin
        alu_sum = alu_a - alu_b;
        alu_v = (alu_a[31] != alu_b[31]) &&
                (alu_sum[31] != alu_a[31]);
      end
      3'b111:
        alu_sum = {31'h0,
                   $signed(alu_a) < $signed(alu_b)};
      default: alu_sum = 32'h0;
    endcase
    alu_zout = (alu_sum == 32'h0);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0;
    req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;

    // reset values
    cyc(); cyc();
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_req1_ready", 32'(req1_ready), 0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_flags", 32'({rsp_z, rsp_n, rsp_v}), 0);
    chk("rst_alu_gin", 32'(alu_gin), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_ops_done", 32'(ops_done), 0);
    rst_n = 1'b1;
    cyc();

    // 1: req0 ADD 0x7FFFFFFF + 1
    req0_valid = 1; req0_op = 3'b010;
    req0_a = 32'h7FFF_FFFF; req0_b = 32'h1;
    rsp0_ready = 1;
    settle();
    chk("add_req0_ready", 32'(req0_ready), 1);
    chk("add_req1_ready", 32'(req1_ready), 0);
    cyc();
    req0_valid = 0;
    settle();
    chk("add_exec_ready", 32'(req0_ready), 0);
    chk("add_exec_gin", 32'(alu_gin), 32'h2);
    chk("add_exec_a", alu_a, 32'h7FFF_FFFF);
    chk("add_exec_nrsp", 32'(rsp0_valid), 0);
    cyc();
    chk("add_rsp_valid", 32'(rsp0_valid), 1);
    chk("add_result", rsp_result, 32'h8000_0000);
    chk("add_znv", 32'({rsp_z, rsp_n, rsp_v}), 32'b011);
    cyc();
    chk("add_done_valid", 32'(rsp0_valid), 0);
    chk("add_ops_done", 32'(ops_done), 1);

    // 2: tie from reset, both SUB 5-5
    rst_n = 0; settle(); rst_n = 1;
    cyc();
    req0_valid = 1; req0_op = 3'b110;
    req0_a = 5; req0_b = 5;
    req1_valid = 1; req1_op = 3'b110;
    req1_a = 5; req1_b = 5;
    rsp0_ready = 1; rsp1_ready = 1;
    settle();
    chk("tie_req0_ready", 32'(req0_ready), 1);
    chk("tie_req1_ready", 32'(req1_ready), 0);
    cyc();
    req0_valid = 0;
    settle();
    chk("tie_exec_r1rdy", 32'(req1_ready), 0);
    cyc();
    chk("tie_rsp0_valid", 32'(rsp0_valid), 1);
    chk("tie_rsp1_quiet", 32'(rsp1_valid), 0);
    chk("tie_res0", rsp_result, 0);
    chk("tie_z0", 32'(rsp_z), 1);
    cyc();
    chk("tie_req1_ready", 32'(req1_ready), 1);
    chk("tie_rsp0_gone", 32'(rsp0_valid), 0);
    cyc();
    req1_valid = 0;
    cyc();
    chk("tie_rsp1_valid", 32'(rsp1_valid), 1);
    chk("tie_rsp0_quiet", 32'(rsp0_valid), 0);
    chk("tie_res1", rsp_result, 0);
    chk("tie_z1", 32'(rsp_z), 1);
    cyc();
    chk("tie_ops_done", 32'(ops_done), 2);

    // 3: req1 SLT -1 < 1 with 4-cycle stall;
    //    req0 held valid during the stall
    req1_valid = 1; req1_op = 3'b111;
    req1_a = 32'hFFFF_FFFF; req1_b = 32'h1;
    rsp1_ready = 0;
    settle();
    chk("slt_req1_ready", 32'(req1_ready), 1);
    cyc();
    req1_valid = 0;
    req0_valid = 1; req0_op = 3'b000;
    req0_a = 32'hF0F0_F0F0; req0_b = 32'h0FF0_0FF0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("slt_stall_valid", 32'(rsp1_valid), 1);
      chk("slt_stall_result", rsp_result, 1);
      chk("slt_stall_znv",
          32'({rsp_z, rsp_n, rsp_v}), 32'b010);
      chk("slt_stall_r0rdy", 32'(req0_ready), 0);
      cyc();
    end
    rsp1_ready = 1;
    settle();
    chk("slt_still_valid", 32'(rsp1_valid), 1);
    chk("slt_ops_hold", 32'(ops_done), 2);
    cyc();
    chk("slt_rsp_gone", 32'(rsp1_valid), 0);
    chk("slt_ops_done", 32'(ops_done), 3);

    // 4: back-to-back req0 AND then OR
    chk("and_req0_ready", 32'(req0_ready), 1);
    cyc();
    chk("and_exec_ready", 32'(req0_ready), 0);
    cyc();
    chk("and_rsp_valid", 32'(rsp0_valid), 1);
    chk("and_result", rsp_result, 32'h00F0_00F0);
    chk("and_znv", 32'({rsp_z, rsp_n, rsp_v}), 0);
    chk("and_rsp_ready", 32'(req0_ready), 0);
    req0_op = 3'b001;
    cyc();
    chk("or_req0_ready", 32'(req0_ready), 1);
    cyc();
    req0_valid = 0;
    cyc();
    chk("or_rsp_valid", 32'(rsp0_valid), 1);
    chk("or_result", rsp_result, 32'hFFF0_FFF0);
    chk("or_znv", 32'({rsp_z, rsp_n, rsp_v}), 32'b010);
    cyc();
    chk("or_ops_done", 32'(ops_done), 5);

    // 5: reset during EXEC of req1 ADD
    req1_valid = 1; req1_op = 3'b010;
    req1_a = 3; req1_b = 4;
    settle();
    chk("rm_req1_ready", 32'(req1_ready), 1);
    cyc();
    req1_valid = 0;
    settle();
    chk("rm_exec_gin", 32'(alu_gin), 32'h2);
    rst_n = 0;
    settle();
    chk("rm_rsp1_valid", 32'(rsp1_valid), 0);
    chk("rm_result", rsp_result, 0);
    chk("rm_alu_gin", 32'(alu_gin), 0);
    chk("rm_alu_a", alu_a, 0);
    chk("rm_alu_b", alu_b, 0);
    chk("rm_ops_done", 32'(ops_done), 0);
    cyc();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rm_no_rsp1", 32'(rsp1_valid), 0);
    end
    chk("rm_ops_after", 32'(ops_done), 0);

`ifdef ALU_SHARE_ARB_ILLEGAL_OP_EN
    // 6: illegal op bypasses the ALU
    req0_valid = 1; req0_op = 3'b011;
    req0_a = 32'h1234; req0_b = 32'h5678;
    rsp0_ready = 1;
    settle();
    chk("ill_req0_ready", 32'(req0_ready), 1);
    cyc();
    req0_valid = 0;
    chk("ill_rsp_valid", 32'(rsp0_valid), 1);
    chk("ill_err", 32'(rsp_err), 1);
    chk("ill_result", rsp_result, 0);
    chk("ill_znv", 32'({rsp_z, rsp_n, rsp_v}), 0);
    chk("ill_alu_gin", 32'(alu_gin), 0);
    cyc();
    req0_valid = 1; req0_op = 3'b010;
    req0_a = 1; req0_b = 2;
    cyc();
    req0_valid = 0;
    cyc();
    chk("leg_rsp_valid", 32'(rsp0_valid), 1);
    chk("leg_err", 32'(rsp_err), 0);
    chk("leg_result", rsp_result, 3);
    cyc();
    chk("leg_ops_done", 32'(ops_done), 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
